// File: rtl/text_lcd_ctrl_param.sv
// rtl/text_lcd_ctrl_param.sv - HD44780-style 8-bit text LCD controller with writable char buffer
// LCD pins are registered from the decoded state, so the bus trails the internal step by one cycle.
module text_lcd_ctrl_param #(
    parameter int CLK_DIV     = 100,
    parameter int ROWS        = 2,
    parameter int COLS        = 16,
    parameter int INIT_STEPS  = 70,
    parameter int CLEAR_STEPS = 20,
    localparam int NCH        = ROWS * COLS,
    localparam int AW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic          refresh,
    output logic          busy,
    output logic          init_done,
    output logic          LCD_E,
    output logic          LCD_RS,
    output logic          LCD_RW,
    output logic [7:0]    LCD_DATA,
    output logic [7:0]    LED_out
);

    localparam int PW   = $clog2(CLK_DIV);
    localparam int CMAX = (INIT_STEPS > COLS) ?
                          ((INIT_STEPS > CLEAR_STEPS) ? INIT_STEPS : CLEAR_STEPS) :
                          ((COLS > CLEAR_STEPS) ? COLS : CLEAR_STEPS);
    localparam int CW   = $clog2(CMAX + 2);

    typedef enum logic [3:0] {
        S_POWERUP    = 4'd0,
        S_FUNC_SET   = 4'd1,
        S_DISP_ON    = 4'd2,
        S_ENTRY      = 4'd3,
        S_CLEAR      = 4'd4,
        S_IDLE       = 4'd5,
        S_SET_ADDR   = 4'd6,
        S_WRITE_CHAR = 4'd7
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ph_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      row_q;
    logic            pending_q;
    logic            init_done_q;
    logic [7:0]      buf_q [NCH];
    logic            lcd_e_q, lcd_rs_q;
    logic [7:0]      lcd_data_q;
    logic            e_d, rs_d;
    logic [7:0]      data_d;
    logic [7:0]      row_base;
    logic [AW-1:0]   rd_idx;
    logic            step_end;

    assign step_end = (ph_q == PW'(CLK_DIV - 1));
    assign rd_idx   = AW'(int'(row_q) * COLS + int'(cnt_q));

    always_comb begin
        case (row_q)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'h14;
            default: row_base = 8'h54;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_POWERUP;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_POWERUP:    if (step_end && cnt_q == CW'(INIT_STEPS - 1)) state_d = S_FUNC_SET;
            S_FUNC_SET:   if (step_end) state_d = S_DISP_ON;
            S_DISP_ON:    if (step_end) state_d = S_ENTRY;
            S_ENTRY:      if (step_end) state_d = S_CLEAR;
            // step 0 of CLEAR is the command itself, the rest are settling steps
            S_CLEAR:      if (step_end && cnt_q == CW'(CLEAR_STEPS)) state_d = S_SET_ADDR;
            S_IDLE:       if (refresh || pending_q) state_d = S_SET_ADDR;
            S_SET_ADDR:   if (step_end) state_d = S_WRITE_CHAR;
            S_WRITE_CHAR: if (step_end && cnt_q == CW'(COLS - 1))
                              state_d = (row_q == 2'(ROWS - 1)) ? S_IDLE : S_SET_ADDR;
            default:      state_d = S_POWERUP;
        endcase
    end

    always_comb begin
        rs_d   = lcd_rs_q;
        data_d = lcd_data_q;
        e_d    = 1'b0;
        if (ph_q == '0) begin
            case (state_q)
                S_POWERUP:    begin rs_d = 1'b0; data_d = 8'h00; end
                S_FUNC_SET:   begin rs_d = 1'b0; data_d = 8'h38; end
                S_DISP_ON:    begin rs_d = 1'b0; data_d = 8'h0C; end
                S_ENTRY:      begin rs_d = 1'b0; data_d = 8'h06; end
                S_CLEAR:      begin rs_d = 1'b0; data_d = 8'h01; end
                S_SET_ADDR:   begin rs_d = 1'b0; data_d = 8'h80 | row_base; end
                S_WRITE_CHAR: begin rs_d = 1'b1; data_d = buf_q[rd_idx]; end
                default:      ;
            endcase
        end
        if (ph_q >= PW'(CLK_DIV / 4) && ph_q < PW'(3 * CLK_DIV / 4)) begin
            case (state_q)
                S_FUNC_SET, S_DISP_ON, S_ENTRY,
                S_SET_ADDR, S_WRITE_CHAR: e_d = 1'b1;
                S_CLEAR:                  e_d = (cnt_q == '0);
                default:                  e_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q        <= '0;
            cnt_q       <= '0;
            row_q       <= '0;
            pending_q   <= 1'b0;
            init_done_q <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
        end else begin
            ph_q <= (state_q == S_IDLE || step_end) ? '0 : ph_q + PW'(1);
            if (state_d != state_q) cnt_q <= '0;
            else if (step_end)      cnt_q <= cnt_q + CW'(1);
            if (state_q == S_WRITE_CHAR && state_d == S_SET_ADDR)
                row_q <= row_q + 2'd1;
            else if (state_q != S_SET_ADDR && state_q != S_WRITE_CHAR)
                row_q <= '0;
            // requests arriving while busy coalesce into a single follow-up redraw
            if (state_q == S_IDLE) pending_q <= 1'b0;
            else if (refresh)      pending_q <= 1'b1;
            if (state_q == S_CLEAR && state_d == S_SET_ADDR) init_done_q <= 1'b1;
            lcd_e_q    <= e_d;
            lcd_rs_q   <= rs_d;
            lcd_data_q <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) buf_q[i] <= 8'h20;
        end else if (wr_en && int'(wr_addr) < NCH) begin
            buf_q[wr_addr] <= wr_char;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign init_done = init_done_q;
    assign LCD_E     = lcd_e_q;
    assign LCD_RS    = lcd_rs_q;
    assign LCD_RW    = 1'b0;
    assign LCD_DATA  = lcd_data_q;
    assign LED_out   = {init_done_q, busy, 2'b00, state_q};

endmodule
